// File: rtl/riscv_pkg.sv
// Shared RV32I control types for the multi-cycle sequencer: opcodes, ALU ops,
// write-back selects and sequencer states.
package riscv_pkg;

  localparam int unsigned OpWidth     = 7;
  localparam int unsigned Funct3Width = 3;
  localparam int unsigned Funct7Width = 7;
  localparam int unsigned AluOpWidth  = 4;
  localparam int unsigned WbSelWidth  = 2;
  localparam int unsigned StateWidth  = 3;

  typedef enum logic [OpWidth-1:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [AluOpWidth-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_EQ     = 4'd10,
    ALU_NE     = 4'd11,
    ALU_GE     = 4'd12,
    ALU_GEU    = 4'd13,
    ALU_PASS_B = 4'd14
  } alu_op_e;

  typedef enum logic [WbSelWidth-1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [StateWidth-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } ctrl_state_e;

  function automatic logic is_legal_op(input logic [OpWidth-1:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: is_legal_op = 1'b1;
      default:                            is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Signal bundle between the multi-cycle sequencer and the RV32I datapath and memories.
interface multicycle_ctrl_if #(
  parameter int unsigned CntWidth = 32
);
  import riscv_pkg::*;

  logic [OpWidth-1:0]     op_code_i;
  logic [Funct3Width-1:0] funct3_i;
  logic [Funct7Width-1:0] funct7_i;
  logic                   imem_ready_i;
  logic                   dmem_ready_i;
  logic                   imem_req_o;
  logic                   ir_wr_en_o;
  logic                   pc_wr_en_o;
  logic                   jal_o;
  logic                   jalr_o;
  logic                   branch_o;
  logic                   regf_wr_en_o;
  logic                   mem_r_en_o;
  logic                   mem_wr_en_o;
  logic                   alu_src2_sel_o;
  wb_sel_e                wb_sel_o;
  alu_op_e                alu_op_o;
  logic                   illegal_o;
  logic [CntWidth-1:0]    instret_o;

  modport master (
    input  op_code_i, funct3_i, funct7_i, imem_ready_i, dmem_ready_i,
    output imem_req_o, ir_wr_en_o, pc_wr_en_o, jal_o, jalr_o, branch_o,
           regf_wr_en_o, mem_r_en_o, mem_wr_en_o, alu_src2_sel_o,
           wb_sel_o, alu_op_o, illegal_o, instret_o
  );

  modport slave (
    output op_code_i, funct3_i, funct7_i, imem_ready_i, dmem_ready_i,
    input  imem_req_o, ir_wr_en_o, pc_wr_en_o, jal_o, jalr_o, branch_o,
           regf_wr_en_o, mem_r_en_o, mem_wr_en_o, alu_src2_sel_o,
           wb_sel_o, alu_op_o, illegal_o, instret_o
  );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode from opcode/funct3/funct7.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [OpWidth-1:0]     op_code_i,
  input  logic [Funct3Width-1:0] funct3_i,
  input  logic [Funct7Width-1:0] funct7_i,
  output alu_op_e                alu_op_o
);

  logic w_alt;
  logic w_unused;

  // Only funct7[5] selects an alternate operation; the other bits carry no meaning here.
  assign w_alt    = funct7_i[5];
  assign w_unused = ^{funct7_i[6], funct7_i[4:0]};

  always_comb begin
    alu_op_o = ALU_ADD;
    case (op_code_i)
      OP_REG, OP_IMM: begin
        case (funct3_i)
          3'b000:  alu_op_o = (op_code_i == OP_REG && w_alt) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op_o = ALU_SLL;
          3'b010:  alu_op_o = ALU_SLT;
          3'b011:  alu_op_o = ALU_SLTU;
          3'b100:  alu_op_o = ALU_XOR;
          3'b101:  alu_op_o = w_alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op_o = ALU_OR;
          default: alu_op_o = ALU_AND;
        endcase
      end
      OP_BRANCH: begin
        case (funct3_i)
          3'b000:  alu_op_o = ALU_EQ;
          3'b001:  alu_op_o = ALU_NE;
          3'b100:  alu_op_o = ALU_SLT;
          3'b101:  alu_op_o = ALU_GE;
          3'b110:  alu_op_o = ALU_SLTU;
          3'b111:  alu_op_o = ALU_GEU;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      OP_LUI:  alu_op_o = ALU_PASS_B;
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH..WB per instruction with memory ready
// handshakes, retire counter and sticky illegal-opcode flag.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned CntWidth = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  multicycle_ctrl_if.master bus
);

  ctrl_state_e         r_state;
  ctrl_state_e         w_next;
  logic                r_illegal;
  logic [CntWidth-1:0] r_instret;

  alu_op_e w_dec_alu_op;
  alu_op_e w_alu_op;
  wb_sel_e w_wb_sel;
  logic    w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr, w_is_reg;
  logic    w_imem_req, w_ir_wr_en, w_retire, w_jal, w_jalr, w_branch;
  logic    w_regf_wr_en, w_mem_r_en, w_mem_wr_en, w_alu_src2_sel, w_set_illegal;

  alu_decoder u_alu_decoder (
    .op_code_i (bus.op_code_i),
    .funct3_i  (bus.funct3_i),
    .funct7_i  (bus.funct7_i),
    .alu_op_o  (w_dec_alu_op)
  );

  assign w_is_load   = (bus.op_code_i == OP_LOAD);
  assign w_is_store  = (bus.op_code_i == OP_STORE);
  assign w_is_branch = (bus.op_code_i == OP_BRANCH);
  assign w_is_jal    = (bus.op_code_i == OP_JAL);
  assign w_is_jalr   = (bus.op_code_i == OP_JALR);
  assign w_is_reg    = (bus.op_code_i == OP_REG);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_FETCH;
    else       r_state <= w_next;
  end

  // Strobes are forced low while reset is held so an aborted access never lingers.
  always_comb begin
    w_next         = r_state;
    w_imem_req     = 1'b0;
    w_ir_wr_en     = 1'b0;
    w_retire       = 1'b0;
    w_jal          = 1'b0;
    w_jalr         = 1'b0;
    w_branch       = 1'b0;
    w_regf_wr_en   = 1'b0;
    w_mem_r_en     = 1'b0;
    w_mem_wr_en    = 1'b0;
    w_alu_src2_sel = 1'b0;
    w_alu_op       = ALU_ADD;
    w_wb_sel       = WB_ALU;
    w_set_illegal  = 1'b0;
    if (!rst_i) begin
      case (r_state)
        ST_FETCH: begin
          w_imem_req = 1'b1;
          if (bus.imem_ready_i) begin
            w_ir_wr_en = 1'b1;
            w_next     = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_legal_op(bus.op_code_i)) begin
            w_next = ST_EXEC;
          end else begin
            w_set_illegal = 1'b1;
            w_next        = ST_TRAP;
          end
        end
        ST_EXEC: begin
          w_alu_op       = w_dec_alu_op;
          w_alu_src2_sel = !(w_is_reg || w_is_branch);
          if (w_is_branch) begin
            w_branch = 1'b1;
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end else if (w_is_load || w_is_store) begin
            w_next = ST_MEM;
          end else begin
            w_next = ST_WB;
          end
        end
        ST_MEM: begin
          w_alu_op       = w_dec_alu_op;
          w_alu_src2_sel = 1'b1;
          w_mem_r_en     = w_is_load;
          w_mem_wr_en    = !w_is_load;
          if (bus.dmem_ready_i) begin
            if (w_is_load) begin
              w_next = ST_WB;
            end else begin
              w_retire = 1'b1;
              w_next   = ST_FETCH;
            end
          end
        end
        ST_WB: begin
          w_alu_op       = w_dec_alu_op;
          w_alu_src2_sel = !w_is_reg;
          w_regf_wr_en   = 1'b1;
          w_retire       = 1'b1;
          w_jal          = w_is_jal;
          w_jalr         = w_is_jalr;
          w_wb_sel       = w_is_load ? WB_MEM : ((w_is_jal || w_is_jalr) ? WB_PC4 : WB_ALU);
          w_next         = ST_FETCH;
        end
        ST_TRAP: w_next = ST_TRAP;
        default: w_next = ST_FETCH;
      endcase
    end
  end

  // Retire counter wraps silently; illegal flag is sticky until reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_retire)      r_instret <= r_instret + CntWidth'(1);
    end
  end

  assign bus.imem_req_o     = w_imem_req;
  assign bus.ir_wr_en_o     = w_ir_wr_en;
  assign bus.pc_wr_en_o     = w_retire;
  assign bus.jal_o          = w_jal;
  assign bus.jalr_o         = w_jalr;
  assign bus.branch_o       = w_branch;
  assign bus.regf_wr_en_o   = w_regf_wr_en;
  assign bus.mem_r_en_o     = w_mem_r_en;
  assign bus.mem_wr_en_o    = w_mem_wr_en;
  assign bus.alu_src2_sel_o = w_alu_src2_sel;
  assign bus.wb_sel_o       = w_wb_sel;
  assign bus.alu_op_o       = w_alu_op;
  assign bus.illegal_o      = r_illegal;
  assign bus.instret_o      = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction expectations are queued when
// issued and popped when the sequencer retires the instruction.
module tb_multicycle_ctrl;
  import riscv_pkg::*;

  localparam int unsigned CntWidth = 32;
  localparam int unsigned SmallCnt = 2;

  typedef struct {
    alu_op_e alu;
    logic    src2;
    logic    regf;
    wb_sel_e wb;
    logic    jal;
    logic    jalr;
    logic    br;
    logic    rd;
    logic    wr;
    int      done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;
  int   exp_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CntWidth(CntWidth)) bus ();
  multicycle_ctrl_if #(.CntWidth(SmallCnt)) bus2 ();

  // The narrow-counter instance sees identical stimulus and exercises wrap-around.
  assign bus2.op_code_i    = bus.op_code_i;
  assign bus2.funct3_i     = bus.funct3_i;
  assign bus2.funct7_i     = bus.funct7_i;
  assign bus2.imem_ready_i = bus.imem_ready_i;
  assign bus2.dmem_ready_i = bus.dmem_ready_i;

  multicycle_ctrl #(.CntWidth(CntWidth)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  multicycle_ctrl #(.CntWidth(SmallCnt)) dut_small (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strobes();
    return 32'({bus.imem_req_o, bus.ir_wr_en_o, bus.pc_wr_en_o, bus.jal_o, bus.jalr_o,
                bus.branch_o, bus.regf_wr_en_o, bus.mem_r_en_o, bus.mem_wr_en_o,
                bus.alu_src2_sel_o, bus.wb_sel_o, bus.alu_op_o});
  endfunction

  function automatic exp_t mk(input alu_op_e alu, input logic src2, input logic regf,
                              input wb_sel_e wb, input logic jal, input logic jalr,
                              input logic br, input logic rd, input logic wr, input int done_cyc);
    exp_t e;
    e.alu = alu; e.src2 = src2; e.regf = regf; e.wb = wb; e.jal = jal; e.jalr = jalr;
    e.br = br; e.rd = rd; e.wr = wr; e.done_cyc = done_cyc;
    return e;
  endfunction

  // Runs one instruction from FETCH to retirement; entered and left at posedge+1 in FETCH.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input int iwait, input int dwait, input exp_t e);
    int   cyc        = 0;
    int   mem_rd_cyc = 0;
    int   mem_wr_cyc = 0;
    int   ir_cnt     = 0;
    int   regw       = 0;
    bit   done       = 1'b0;
    exp_t got;
    bus.op_code_i = op;
    bus.funct3_i  = f3;
    bus.funct7_i  = f7;
    sb.push_back(e);
    while (!done && cyc < 40) begin
      bus.imem_ready_i = (cyc >= iwait);
      if (bus.mem_r_en_o || bus.mem_wr_en_o) bus.dmem_ready_i = ((mem_rd_cyc + mem_wr_cyc) >= dwait);
      else                                   bus.dmem_ready_i = 1'b1;
      @(negedge clk);
      if (cyc < iwait) chk({tag, "_imem_req_hold"}, 32'(bus.imem_req_o), 32'd1);
      if (bus.ir_wr_en_o)   ir_cnt++;
      if (bus.mem_r_en_o)   mem_rd_cyc++;
      if (bus.mem_wr_en_o)  mem_wr_cyc++;
      if (bus.regf_wr_en_o) regw++;
      if (cyc == iwait + 2) begin
        chk({tag, "_alu_op"}, 32'(bus.alu_op_o), 32'(e.alu));
        chk({tag, "_src2"}, 32'(bus.alu_src2_sel_o), 32'(e.src2));
      end
      if (bus.pc_wr_en_o) begin
        got  = sb.pop_front();
        done = 1'b1;
        chk({tag, "_retire_cycle"}, 32'(cyc), 32'(got.done_cyc));
        chk({tag, "_regf_wr"}, 32'(bus.regf_wr_en_o), 32'(got.regf));
        chk({tag, "_wb_sel"}, 32'(bus.wb_sel_o), 32'(got.wb));
        chk({tag, "_jal"}, 32'(bus.jal_o), 32'(got.jal));
        chk({tag, "_jalr"}, 32'(bus.jalr_o), 32'(got.jalr));
        chk({tag, "_branch"}, 32'(bus.branch_o), 32'(got.br));
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_retired"}, 32'(done), 32'd1);
    if (!done) sb.delete();
    exp_cnt++;
    chk({tag, "_instret"}, bus.instret_o, 32'(exp_cnt));
    chk({tag, "_instret_small"}, 32'(bus2.instret_o), 32'(exp_cnt % 4));
    chk({tag, "_pc_wr_after"}, 32'(bus.pc_wr_en_o), 32'd0);
    chk({tag, "_ir_wr_count"}, 32'(ir_cnt), 32'd1);
    chk({tag, "_mem_rd_cycles"}, 32'(mem_rd_cyc), e.rd ? 32'(dwait + 1) : 32'd0);
    chk({tag, "_mem_wr_cycles"}, 32'(mem_wr_cyc), e.wr ? 32'(dwait + 1) : 32'd0);
    chk({tag, "_regf_count"}, 32'(regw), 32'(e.regf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.op_code_i    = 7'd0;
    bus.funct3_i     = 3'd0;
    bus.funct7_i     = 7'd0;
    bus.imem_ready_i = 1'b1;
    bus.dmem_ready_i = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_strobes", strobes(), 32'd0);
    chk("rst_illegal", 32'(bus.illegal_o), 32'd0);
    chk("rst_instret", bus.instret_o, 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(ST_FETCH));
    bus.imem_ready_i = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Main instruction mix
    run_instr("add",  7'b0110011, 3'b000, 7'b0000000, 0, 0,
              mk(ALU_ADD,    1'b0, 1'b1, WB_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3));
    run_instr("sub",  7'b0110011, 3'b000, 7'b0100000, 2, 0,
              mk(ALU_SUB,    1'b0, 1'b1, WB_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5));
    run_instr("srai", 7'b0010011, 3'b101, 7'b0100000, 0, 0,
              mk(ALU_SRA,    1'b1, 1'b1, WB_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3));
    run_instr("lw",   7'b0000011, 3'b010, 7'b0000000, 0, 3,
              mk(ALU_ADD,    1'b1, 1'b1, WB_MEM, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7));
    run_instr("sw",   7'b0100011, 3'b010, 7'b0000000, 1, 0,
              mk(ALU_ADD,    1'b1, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4));
    run_instr("beq",  7'b1100011, 3'b000, 7'b0000000, 0, 0,
              mk(ALU_EQ,     1'b0, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2));
    run_instr("bgeu", 7'b1100011, 3'b111, 7'b0000000, 0, 0,
              mk(ALU_GEU,    1'b0, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2));
    run_instr("blt",  7'b1100011, 3'b100, 7'b0000000, 0, 0,
              mk(ALU_SLT,    1'b0, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2));
    run_instr("jal",  7'b1101111, 3'b000, 7'b0000000, 0, 0,
              mk(ALU_ADD,    1'b1, 1'b1, WB_PC4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3));
    run_instr("jalr", 7'b1100111, 3'b000, 7'b0000000, 0, 0,
              mk(ALU_ADD,    1'b1, 1'b1, WB_PC4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3));
    run_instr("lui",  7'b0110111, 3'b000, 7'b0000000, 0, 0,
              mk(ALU_PASS_B, 1'b1, 1'b1, WB_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3));
    run_instr("addi_f7", 7'b0010011, 3'b000, 7'b0100000, 0, 0,
              mk(ALU_ADD,    1'b1, 1'b1, WB_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3));
    run_instr("srl",  7'b0110011, 3'b101, 7'b0000000, 0, 0,
              mk(ALU_SRL,    1'b0, 1'b1, WB_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3));
    run_instr("and",  7'b0110011, 3'b111, 7'b0000000, 0, 0,
              mk(ALU_AND,    1'b0, 1'b1, WB_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3));

    // Illegal opcode traps permanently
    bus.op_code_i    = 7'b1111111;
    bus.imem_ready_i = 1'b1;
    bus.dmem_ready_i = 1'b1;
    @(negedge clk);
    chk("ill_ir_wr", 32'(bus.ir_wr_en_o), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ill_decode_flag", 32'(bus.illegal_o), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ill_trap_strobes", strobes(), 32'd0);
      chk("ill_trap_flag", 32'(bus.illegal_o), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("ill_instret", bus.instret_o, 32'(exp_cnt));
    rst = 1'b1;
    #1;
    chk("ill_rst_flag", 32'(bus.illegal_o), 32'd0);
    chk("ill_rst_instret", bus.instret_o, 32'd0);
    exp_cnt = 0;
    bus.imem_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset during a stalled store aborts it
    bus.op_code_i    = 7'b0100011;
    bus.funct3_i     = 3'b010;
    bus.funct7_i     = 7'd0;
    bus.imem_ready_i = 1'b1;
    bus.dmem_ready_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("swrst_mem_wr_before", 32'(bus.mem_wr_en_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("swrst_mem_wr_after", 32'(bus.mem_wr_en_o), 32'd0);
    chk("swrst_state", 32'(dut.r_state), 32'(ST_FETCH));
    chk("swrst_instret", bus.instret_o, 32'd0);
    chk("swrst_instret_small", 32'(bus2.instret_o), 32'd0);
    bus.imem_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_instr("add_after_rst", 7'b0110011, 3'b000, 7'b0000000, 0, 0,
              mk(ALU_ADD, 1'b0, 1'b1, WB_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
